dl_mem_arbiter: RTL and testbench

//  Downstream stage of the download path: takes the downloader's wr/addr/data/downloading stream and

---
 rtl/dl_pkg.sv | 30 +++
 rtl/dl_wr_fifo.sv | 60 ++++++
 rtl/dl_mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_dl_mem_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dl_pkg.sv
// -----------------------------------------------------------------------------
// dl_pkg
//   Shared types and constants for the download-path memory arbiter.
//   - dl_state_t   : arbiter bus-ownership states
//   - DL_ADDR_IN_W : width of the downloader byte address
//   - dl_in_range  : true when a downloader address fits in an aw-bit memory
// -----------------------------------------------------------------------------
package dl_pkg;

   localparam int DL_ADDR_IN_W = 25;
   localparam int DL_DATA_W    = 8;

   // IDLE   : CPU owns the memory port
   // DL     : downloader active, buffered writes issued on slots
   // DRAIN  : downloader finished, emptying the buffer
   // SETTLE : buffer empty, bus held a few cycles before returning it to the CPU
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DL     = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_SETTLE = 2'd3
   } dl_state_t;

   // Any address bit at or above aw set means the byte lies outside the memory.
   function automatic logic dl_in_range(input logic [DL_ADDR_IN_W-1:0] addr,
                                        input int unsigned aw);
      return (addr >> aw) == '0;
   endfunction

endpackage

// File: rtl/dl_wr_fifo.sv
// -----------------------------------------------------------------------------
// dl_wr_fifo
//   Small synchronous FIFO buffering download writes until a memory slot.
//   Head entry is presented combinationally on o_dout whenever not empty.
//   Ports:
//     i_clk, i_rst_n   clock, asynchronous active-low reset (flushes pointers)
//     i_push, i_din    write one entry (ignored when full and not popping)
//     i_pop            discard head entry (ignored when empty)
//     o_dout           head entry
//     o_full, o_empty  occupancy flags
// -----------------------------------------------------------------------------
module dl_wr_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW:0]      r_wr_ptr;
   logic [PW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                    (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

   // A pop in the same cycle frees the slot, so a push on a full FIFO is kept.
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_din;
   end

   assign o_dout = r_mem[r_rd_ptr[PW-1:0]];

endmodule

// File: rtl/dl_mem_arbiter.sv
// -----------------------------------------------------------------------------
// dl_mem_arbiter
//   Arbitrates the downloader write stream against the Z80 CPU for the single
//   system memory port. Download writes are buffered and issued one per
//   memory slot; the CPU is held in WAIT while the downloader owns the bus and
//   released SETTLE_CYC cycles after the last buffered write has landed.
//   Ports:
//     i_clk, i_rst_n        clock, asynchronous active-low reset
//     i_dl_downloading      downloader owns memory (level)
//     i_dl_wr               write strobe, one write per rising edge
//     i_dl_addr, i_dl_data  downloader byte address / data
//     i_cpu_addr, i_cpu_dout, i_cpu_wr, i_cpu_rd   CPU access request
//     o_cpu_wait_n          CPU WAIT, active low
//     i_mem_slot            memory accepts one access this cycle
//     o_mem_addr, o_mem_din, o_mem_we, o_mem_ce    memory port
//     o_dl_busy             arbiter owns the bus
//     o_err_ovf, o_err_range  sticky capture errors (reset only)
// -----------------------------------------------------------------------------
module dl_mem_arbiter
   import dl_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int SETTLE_CYC = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_dl_downloading,
   input  logic                    i_dl_wr,
   input  logic [DL_ADDR_IN_W-1:0] i_dl_addr,
   input  logic [DL_DATA_W-1:0]    i_dl_data,
   input  logic [ADDR_W-1:0]       i_cpu_addr,
   input  logic [DL_DATA_W-1:0]    i_cpu_dout,
   input  logic                    i_cpu_wr,
   input  logic                    i_cpu_rd,
   output logic                    o_cpu_wait_n,
   input  logic                    i_mem_slot,
   output logic [ADDR_W-1:0]       o_mem_addr,
   output logic [DL_DATA_W-1:0]    o_mem_din,
   output logic                    o_mem_we,
   output logic                    o_mem_ce,
   output logic                    o_dl_busy,
   output logic                    o_err_ovf,
   output logic                    o_err_range
);

   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   typedef struct packed {
      logic [ADDR_W-1:0]    addr;
      logic [DL_DATA_W-1:0] data;
   } entry_t;

   dl_state_t            r_state;
   dl_state_t            w_state_next;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_cnt_next;
   logic                 r_dl_wr_q;
   logic [ADDR_W-1:0]    r_mem_addr;
   logic [DL_DATA_W-1:0] r_mem_din;
   logic                 r_mem_acc;
   logic                 r_err_ovf;
   logic                 r_err_range;

   logic                 w_rise;
   logic                 w_in_range;
   logic                 w_push_req;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_ovf;
   logic                 w_full;
   logic                 w_empty;
   entry_t               w_push_entry;
   entry_t               w_head;

   // ---------------- write capture (active in every state) ----------------
   assign w_rise       = i_dl_wr & ~r_dl_wr_q;
   assign w_in_range   = dl_in_range(i_dl_addr, ADDR_W);
   assign w_push_req   = w_rise & w_in_range;
   assign w_push       = w_push_req & (~w_full | w_pop);
   assign w_ovf        = w_push_req & w_full & ~w_pop;
   assign w_push_entry = '{addr: i_dl_addr[ADDR_W-1:0], data: i_dl_data};

   // Buffered writes only leave the FIFO while the downloader path owns the bus.
   assign w_pop = ((r_state == ST_DL) || (r_state == ST_DRAIN)) & i_mem_slot & ~w_empty;

   dl_wr_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_din   (w_push_entry),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // ---------------- state register and datapath registers ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_dl_wr_q   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_din   <= '0;
         r_mem_acc   <= 1'b0;
         r_err_ovf   <= 1'b0;
         r_err_range <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_dl_wr_q <= i_dl_wr;
         // One-cycle write pulse per popped entry; address/data hold afterwards.
         r_mem_acc <= w_pop;
         if (w_pop) begin
            r_mem_addr <= w_head.addr;
            r_mem_din  <= w_head.data;
         end
         if (w_ovf)                  r_err_ovf   <= 1'b1;
         if (w_rise && !w_in_range)  r_err_range <= 1'b1;
      end
   end

   // ---------------- next state and output mux ----------------
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      o_mem_addr   = r_mem_addr;
      o_mem_din    = r_mem_din;
      o_mem_we     = r_mem_acc;
      o_mem_ce     = r_mem_acc;
      o_cpu_wait_n = 1'b0;
      o_dl_busy    = 1'b1;

      case (r_state)
         ST_IDLE: begin
            o_mem_addr   = i_cpu_addr;
            o_mem_din    = i_cpu_dout;
            o_mem_we     = i_cpu_wr;
            o_mem_ce     = i_cpu_rd | i_cpu_wr;
            // WAIT goes low in the same cycle the downloader takes over, so a
            // CPU access caught mid-flight is retried after release.
            o_cpu_wait_n = ~i_dl_downloading;
            o_dl_busy    = 1'b0;
            if (i_dl_downloading) w_state_next = ST_DL;
         end
         ST_DL: begin
            if (!i_dl_downloading) w_state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (i_dl_downloading) begin
               w_state_next = ST_DL;
            end else if (w_empty && !w_push && !r_mem_acc) begin
               // Last pulse has left the bus; hold it a little longer for settle.
               w_state_next = ST_SETTLE;
               w_cnt_next   = CNT_W'(SETTLE_CYC - 1);
            end
         end
         ST_SETTLE: begin
            if (i_dl_downloading) begin
               w_state_next = ST_DL;
            end else if (r_cnt == '0) begin
               w_state_next = ST_IDLE;
            end else begin
               w_cnt_next = r_cnt - CNT_W'(1);
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign o_err_ovf   = r_err_ovf;
   assign o_err_range = r_err_range;

endmodule

// File: tb/tb_dl_mem_arbiter.sv
module tb_dl_mem_arbiter;

   localparam int ADDR_W     = 16;
   localparam int FIFO_DEPTH = 4;
   localparam int SETTLE_CYC = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dl_downloading = 1'b0;
   logic        dl_wr = 1'b0;
   logic [24:0] dl_addr = '0;
   logic [7:0]  dl_data = '0;
   logic [15:0] cpu_addr = '0;
   logic [7:0]  cpu_dout = '0;
   logic        cpu_wr = 1'b0;
   logic        cpu_rd = 1'b0;
   logic        mem_slot = 1'b0;
   logic        o_cpu_wait_n;
   logic [15:0] o_mem_addr;
   logic [7:0]  o_mem_din;
   logic        o_mem_we;
   logic        o_mem_ce;
   logic        o_dl_busy;
   logic        o_err_ovf;
   logic        o_err_range;

   always #5 clk = ~clk;

   dl_mem_arbiter #(
      .ADDR_W     (ADDR_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .SETTLE_CYC (SETTLE_CYC)
   ) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_dl_downloading (dl_downloading),
      .i_dl_wr          (dl_wr),
      .i_dl_addr        (dl_addr),
      .i_dl_data        (dl_data),
      .i_cpu_addr       (cpu_addr),
      .i_cpu_dout       (cpu_dout),
      .i_cpu_wr         (cpu_wr),
      .i_cpu_rd         (cpu_rd),
      .o_cpu_wait_n     (o_cpu_wait_n),
      .i_mem_slot       (mem_slot),
      .o_mem_addr       (o_mem_addr),
      .o_mem_din        (o_mem_din),
      .o_mem_we         (o_mem_we),
      .o_mem_ce         (o_mem_ce),
      .o_dl_busy        (o_dl_busy),
      .o_err_ovf        (o_err_ovf),
      .o_err_range      (o_err_range)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp, input bit quiet = 1'b0);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else if (!quiet) begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   // ---------------- bus monitor: memory writes issued by the arbiter ----------------
   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t  got[$];
   int   cyc_n = 0;
   int   last_pulse = -1;
   int   rel_cyc = -1;
   int   bad_wait = 0;
   logic prev_wait_n = 1'b1;

   always @(negedge clk) begin
      cyc_n++;
      if (rst_n && o_dl_busy && o_mem_we) begin
         got.push_back('{addr: o_mem_addr, data: o_mem_din});
         last_pulse = cyc_n;
         $display("bus write addr=0x%04h data=0x%02h", o_mem_addr, o_mem_din);
      end
      if (rst_n && o_dl_busy && o_cpu_wait_n) bad_wait++;
      if (o_cpu_wait_n && !prev_wait_n) rel_cyc = cyc_n;
      prev_wait_n = o_cpu_wait_n;
   end

   // ---------------- slot generator: 0 off, 1 every 4th, 2 always, 3 manual ----------------
   int slot_mode = 0;
   int slot_cnt  = 0;
   always @(posedge clk) begin
      #1;
      slot_cnt++;
      case (slot_mode)
         0: mem_slot = 1'b0;
         1: mem_slot = ((slot_cnt % 4) == 0);
         2: mem_slot = 1'b1;
         default: ;
      endcase
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      dl_downloading = 1'b0;
      dl_wr = 1'b0;
      dl_addr = '0;
      dl_data = '0;
      cpu_wr = 1'b0;
      cpu_rd = 1'b0;
      cpu_addr = '0;
      cpu_dout = '0;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      got.delete();
   endtask

   task automatic dl_write(input logic [24:0] a, input logic [7:0] d);
      dl_addr = a;
      dl_data = d;
      dl_wr = 1'b1;
      cyc(1);
      dl_wr = 1'b0;
      cyc(1);
   endtask

   task automatic wait_idle(input string name, input int max_cyc);
      int k = 0;
      while (o_dl_busy && k < max_cyc) begin
         cyc(1);
         k++;
      end
      check(name, {31'd0, o_dl_busy}, 32'd0);
      cyc(1);
   endtask

   task automatic check_got(input string name, input int idx,
                            input logic [15:0] a, input logic [7:0] d);
      if (idx < got.size()) begin
         check($sformatf("%s[%0d] addr", name, idx), 32'(got[idx].addr), 32'(a));
         check($sformatf("%s[%0d] data", name, idx), 32'(got[idx].data), 32'(d));
      end
   endtask

   // ---------------- IDLE pass-through vectors ----------------
   typedef struct {
      logic        dl;
      logic [15:0] a;
      logic [7:0]  d;
      logic        wr;
      logic        rd;
      logic [15:0] ea;
      logic [7:0]  ed;
      logic        ewe;
      logic        ece;
      logic        ewait;
   } vec_t;

   vec_t vt[5];

   // random-phase reference model state
   wr_t         q[$];
   wr_t         e;
   logic        m_prev;
   logic        m_ovf;
   logic        m_rng;
   logic        exp_we;
   logic [15:0] exp_a;
   logic [7:0]  exp_d;
   logic        pop;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{1'b0, 16'h1234, 8'hAB, 1'b1, 1'b0, 16'h1234, 8'hAB, 1'b1, 1'b1, 1'b1};
      vt[1] = '{1'b0, 16'hBEEF, 8'h5A, 1'b0, 1'b1, 16'hBEEF, 8'h5A, 1'b0, 1'b1, 1'b1};
      vt[2] = '{1'b0, 16'h0000, 8'hFF, 1'b0, 1'b0, 16'h0000, 8'hFF, 1'b0, 1'b0, 1'b1};
      vt[3] = '{1'b0, 16'hFFFF, 8'h01, 1'b1, 1'b1, 16'hFFFF, 8'h01, 1'b1, 1'b1, 1'b1};
      // downloader rising while still IDLE: bus still from CPU, WAIT already low
      vt[4] = '{1'b1, 16'h4321, 8'h77, 1'b0, 1'b1, 16'h4321, 8'h77, 1'b0, 1'b1, 1'b0};

      // ---- reset state ----
      rst_n = 1'b0;
      cyc(1);
      check("reset wait_n", {31'd0, o_cpu_wait_n}, 32'd1);
      check("reset busy", {31'd0, o_dl_busy}, 32'd0);
      check("reset mem_we", {31'd0, o_mem_we}, 32'd0);
      check("reset err_ovf", {31'd0, o_err_ovf}, 32'd0);
      check("reset err_range", {31'd0, o_err_range}, 32'd0);
      do_reset();

      // ---- table: IDLE combinational CPU path ----
      for (int i = 0; i < 5; i++) begin
         dl_downloading = vt[i].dl;
         cpu_addr = vt[i].a;
         cpu_dout = vt[i].d;
         cpu_wr = vt[i].wr;
         cpu_rd = vt[i].rd;
         #1;
         check($sformatf("vec%0d mem_addr", i), 32'(o_mem_addr), 32'(vt[i].ea));
         check($sformatf("vec%0d mem_din", i), 32'(o_mem_din), 32'(vt[i].ed));
         check($sformatf("vec%0d mem_we", i), {31'd0, o_mem_we}, {31'd0, vt[i].ewe});
         check($sformatf("vec%0d mem_ce", i), {31'd0, o_mem_ce}, {31'd0, vt[i].ece});
         check($sformatf("vec%0d wait_n", i), {31'd0, o_cpu_wait_n}, {31'd0, vt[i].ewait});
         dl_downloading = 1'b0;
         cyc(1);
      end
      cpu_wr = 1'b0;
      cpu_rd = 1'b0;

      // ---- A: three bytes, slot every 4th cycle ----
      do_reset();
      slot_mode = 1;
      dl_downloading = 1'b1;
      #1;
      check("A wait_n on dl rise", {31'd0, o_cpu_wait_n}, 32'd0);
      cyc(1);
      dl_write(25'h0000, 8'h11);
      dl_write(25'h0001, 8'h22);
      dl_write(25'h0002, 8'h33);
      dl_downloading = 1'b0;
      wait_idle("A return idle", 100);
      check("A write count", got.size(), 3);
      check_got("A", 0, 16'h0000, 8'h11);
      check_got("A", 1, 16'h0001, 8'h22);
      check_got("A", 2, 16'h0002, 8'h33);
      // pulse cycle, one drain-complete cycle, then SETTLE_CYC settle cycles
      check("A release delay", rel_cyc - last_pulse, SETTLE_CYC + 2);

      // ---- B: dl_wr held high five cycles -> one write ----
      do_reset();
      slot_mode = 2;
      dl_downloading = 1'b1;
      cyc(1);
      dl_addr = 25'h0010;
      dl_data = 8'h5C;
      dl_wr = 1'b1;
      cyc(5);
      dl_wr = 1'b0;
      cyc(2);
      dl_downloading = 1'b0;
      wait_idle("B return idle", 50);
      check("B write count", got.size(), 1);
      check_got("B", 0, 16'h0010, 8'h5C);

      // ---- C: overflow with no slots, then drain four ----
      do_reset();
      slot_mode = 0;
      dl_downloading = 1'b1;
      cyc(1);
      for (int i = 0; i < 5; i++) dl_write(25'h0100 + 25'(i), 8'hA0 + 8'(i));
      check("C err_ovf", {31'd0, o_err_ovf}, 32'd1);
      check("C no write without slot", got.size(), 0);
      slot_mode = 2;
      cyc(10);
      check("C writes issued", got.size(), 4);
      for (int i = 0; i < 4; i++) check_got("C", i, 16'h0100 + 16'(i), 8'hA0 + 8'(i));
      dl_downloading = 1'b0;
      wait_idle("C return idle", 50);
      check("C no extra writes", got.size(), 4);

      // ---- D: out-of-range address dropped ----
      do_reset();
      slot_mode = 2;
      dl_downloading = 1'b1;
      cyc(1);
      check("D busy in DL", {31'd0, o_dl_busy}, 32'd1);
      dl_write(25'h10000, 8'h99);
      cyc(3);
      check("D err_range", {31'd0, o_err_range}, 32'd1);
      check("D err_ovf clear", {31'd0, o_err_ovf}, 32'd0);
      dl_downloading = 1'b0;
      wait_idle("D return idle", 50);
      check("D no write", got.size(), 0);

      // ---- E: downloading re-rises during DRAIN ----
      do_reset();
      slot_mode = 0;
      dl_downloading = 1'b1;
      cyc(1);
      dl_write(25'h0200, 8'hC1);
      dl_write(25'h0201, 8'hC2);
      dl_downloading = 1'b0;
      cyc(2);
      check("E busy in drain", {31'd0, o_dl_busy}, 32'd1);
      check("E wait_n in drain", {31'd0, o_cpu_wait_n}, 32'd0);
      dl_downloading = 1'b1;
      cyc(2);
      check("E busy after re-rise", {31'd0, o_dl_busy}, 32'd1);
      check("E wait_n after re-rise", {31'd0, o_cpu_wait_n}, 32'd0);
      slot_mode = 2;
      cyc(6);
      dl_downloading = 1'b0;
      wait_idle("E return idle", 50);
      check("E write count", got.size(), 2);
      check_got("E", 0, 16'h0200, 8'hC1);
      check_got("E", 1, 16'h0201, 8'hC2);

      // ---- F: reset during DRAIN with two pending ----
      do_reset();
      slot_mode = 0;
      dl_downloading = 1'b1;
      cyc(1);
      dl_write(25'h0300, 8'hD1);
      dl_write(25'h0301, 8'hD2);
      dl_downloading = 1'b0;
      cyc(2);
      #2;
      rst_n = 1'b0;
      #1;
      check("F wait_n on reset", {31'd0, o_cpu_wait_n}, 32'd1);
      check("F mem_we on reset", {31'd0, o_mem_we}, 32'd0);
      check("F busy on reset", {31'd0, o_dl_busy}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      got.delete();
      slot_mode = 2;
      dl_downloading = 1'b1;
      cyc(10);
      check("F FIFO flushed", got.size(), 0);
      dl_downloading = 1'b0;
      wait_idle("F return idle", 50);

      // ---- R: randomized stream against a queue model ----
      do_reset();
      slot_mode = 3;
      mem_slot = 1'b0;
      dl_downloading = 1'b1;
      cyc(1);
      q.delete();
      m_prev = 1'b0;
      m_ovf = 1'b0;
      m_rng = 1'b0;
      exp_we = 1'b0;
      exp_a = '0;
      exp_d = '0;
      for (int c = 0; c < 400; c++) begin
         check("R mem_we", {31'd0, o_mem_we}, {31'd0, exp_we}, 1'b1);
         if (exp_we) begin
            check("R mem_addr", 32'(o_mem_addr), 32'(exp_a), 1'b1);
            check("R mem_din", 32'(o_mem_din), 32'(exp_d), 1'b1);
         end
         check("R err_ovf", {31'd0, o_err_ovf}, {31'd0, m_ovf}, 1'b1);
         check("R err_range", {31'd0, o_err_range}, {31'd0, m_rng}, 1'b1);

         dl_wr = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 7) == 0) dl_addr = {9'($urandom_range(1, 511)), 16'($urandom)};
         else                           dl_addr = {9'd0, 16'($urandom)};
         dl_data = 8'($urandom);
         mem_slot = ($urandom_range(0, 4) == 0);

         // model of the coming clock edge: issue oldest first, then capture
         pop = mem_slot && (q.size() > 0);
         exp_we = pop;
         if (pop) begin
            e = q.pop_front();
            exp_a = e.addr;
            exp_d = e.data;
         end
         if (dl_wr && !m_prev) begin
            if (dl_addr >= 25'h10000)         m_rng = 1'b1;
            else if (q.size() == FIFO_DEPTH)  m_ovf = 1'b1;
            else                              q.push_back('{addr: dl_addr[15:0], data: dl_data});
         end
         m_prev = dl_wr;
         cyc(1);
      end
      check("R final mem_we", {31'd0, o_mem_we}, {31'd0, exp_we});
      if (exp_we) q.push_front('{addr: exp_a, data: exp_d});
      got.delete();
      dl_wr = 1'b0;
      slot_mode = 2;
      dl_downloading = 1'b0;
      wait_idle("R return idle", 200);
      check("R drained count", got.size(), q.size());
      for (int i = 0; i < q.size(); i++) check_got("R drain", i, q[i].addr, q[i].data);
      check("CPU held while busy", bad_wait, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
